// File: rtl/rsa_modexp_core.sv
// Modular exponentiation Mo = Mi^k mod N: left-to-right square-and-multiply
// over a bit-serial interleaved modular multiplier (WIDTH cycles per modmul).
module rsa_modexp_core #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned EXP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             ack,
  input  logic [WIDTH-1:0] Mi,
  input  logic [EXP_W-1:0] k,
  input  logic [WIDTH-1:0] N,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [WIDTH-1:0] Mo,
  output logic             o_err
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned IdxW = (EXP_W > 1) ? $clog2(EXP_W) : 1;

  typedef enum logic [2:0] {StIdle, StCheck, StSqr, StMul, StDone} state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  base_q;
  logic [EXP_W-1:0]  e_q;
  logic [WIDTH-1:0]  mod_q;
  logic [WIDTH-1:0]  acc_q;
  logic [WIDTH-1:0]  r_q;
  logic [CntW-1:0]   bit_cnt_q;
  logic [IdxW-1:0]   idx_q;
  logic              o_valid_q;
  logic [WIDTH-1:0]  mo_q;
  logic              o_err_q;

  // One interleaved modmul step; intermediates carry one extra bit so N up
  // to 2^WIDTH-1 never overflows.
  logic [WIDTH-1:0] mul_a;
  logic             mul_b_bit;
  logic [WIDTH:0]   mod_ext;
  logic [WIDTH:0]   r2;
  logic [WIDTH:0]   r2m;
  logic [WIDTH:0]   r3;
  logic [WIDTH-1:0] r_next;

  always_comb begin
    mul_a     = (state_q == StMul) ? base_q : acc_q;
    mul_b_bit = acc_q[bit_cnt_q];
    mod_ext   = {1'b0, mod_q};
    r2        = {r_q, 1'b0};
    r2m       = (r2 >= mod_ext) ? (r2 - mod_ext) : r2;
    r3        = mul_b_bit ? (r2m + {1'b0, mul_a}) : r2m;
    r_next    = (r3 >= mod_ext) ? WIDTH'(r3 - mod_ext) : r3[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      base_q    <= '0;
      e_q       <= '0;
      mod_q     <= '0;
      acc_q     <= '0;
      r_q       <= '0;
      bit_cnt_q <= '0;
      idx_q     <= '0;
      o_valid_q <= 1'b0;
      mo_q      <= '0;
      o_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_valid) begin
            base_q  <= Mi;
            e_q     <= k;
            mod_q   <= N;
            state_q <= StCheck;
          end
        end
        StCheck: begin
          if (mod_q < WIDTH'(2) || base_q >= mod_q) begin
            mo_q      <= '0;
            o_err_q   <= 1'b1;
            o_valid_q <= 1'b1;
            state_q   <= StDone;
          end else begin
            acc_q     <= WIDTH'(1);
            r_q       <= '0;
            bit_cnt_q <= CntW'(WIDTH - 1);
            idx_q     <= IdxW'(EXP_W - 1);
            state_q   <= StSqr;
          end
        end
        StSqr, StMul: begin
          if (bit_cnt_q != '0) begin
            r_q       <= r_next;
            bit_cnt_q <= bit_cnt_q - 1'b1;
          end else begin
            acc_q     <= r_next;
            r_q       <= '0;
            bit_cnt_q <= CntW'(WIDTH - 1);
            if (state_q == StSqr && e_q[idx_q]) begin
              state_q <= StMul;
            end else if (idx_q == '0) begin
              mo_q      <= r_next;
              o_err_q   <= 1'b0;
              o_valid_q <= 1'b1;
              state_q   <= StDone;
            end else begin
              idx_q   <= idx_q - 1'b1;
              state_q <= StSqr;
            end
          end
        end
        StDone: begin
          if (o_ready) begin
            o_valid_q <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // ack is gated by rst so it stays low during the reset cycle itself.
  assign ack     = (state_q == StIdle) && !rst;
  assign o_valid = o_valid_q;
  assign Mo      = mo_q;
  assign o_err   = o_err_q;

endmodule
